// File: rtl/ahb_lite_resp_mux.sv
// AHB-Lite slave-to-master response multiplexor with an embedded default slave.
// The default slave answers unmapped or multiply-decoded transfers with a two-cycle ERROR and counts them.
module ahb_lite_resp_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter int CNT_W      = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NUM_SLAVES-1:0]            HSEL,
    input  logic [1:0]                       HTRANS,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]            HRESP_S,
    input  logic                             ERR_CLR,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HREADY,
    output logic                             HRESP,
    output logic [CNT_W-1:0]                 ERR_CNT,
    output logic                             DEC_FAULT
);

    localparam logic [1:0] DS_OKAY = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Number of set select bits, saturating at 2 (only 0 / 1 / many matter).
    function automatic logic [1:0] sel_count(input logic [NUM_SLAVES-1:0] sel);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel[i] && (cnt != 2'd2)) begin
                cnt = cnt + 2'd1;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    logic [NUM_SLAVES-1:0] dp_sel_r;
    logic                  dp_def_r;
    logic [1:0]            state_r;
    logic [CNT_W-1:0]      err_cnt_r;
    logic                  dec_fault_r;

    logic [1:0]            state_nxt_s;
    logic [1:0]            sel_cnt_s;
    logic                  accept_s;
    logic                  def_hit_s;
    logic                  active_s;
    logic                  err_req_s;
    logic                  err_inc_s;
    logic [DATA_WIDTH-1:0] hrdata_s;
    logic                  hready_s;
    logic                  hresp_s;

    // Response mux: default slave responses come from the FSM, otherwise from the owning slave.
    always_comb begin
        hrdata_s = {DATA_WIDTH{1'b0}};
        hready_s = 1'b1;
        hresp_s  = 1'b0;
        if (dp_def_r) begin
            case (state_r)
                DS_OKAY: begin hready_s = 1'b1; hresp_s = 1'b0; end
                DS_ERR1: begin hready_s = 1'b0; hresp_s = 1'b1; end
                DS_ERR2: begin hready_s = 1'b1; hresp_s = 1'b1; end
                default: begin hready_s = 1'b1; hresp_s = 1'b1; end
            endcase
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dp_sel_r[i]) begin
                    hrdata_s = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                    hready_s = HREADYOUT_S[i];
                    hresp_s  = HRESP_S[i];
                end else begin
                    hrdata_s = hrdata_s;
                end
            end
        end
    end

    // Address-phase decode and default-slave next state.
    always_comb begin
        accept_s  = hready_s;
        sel_cnt_s = sel_count(HSEL);
        def_hit_s = (sel_cnt_s != 2'd1);
        active_s  = (HTRANS == 2'b10) || (HTRANS == 2'b11);
        err_req_s = accept_s && def_hit_s && active_s;
        case (state_r)
            DS_OKAY: state_nxt_s = err_req_s ? DS_ERR1 : DS_OKAY;
            DS_ERR1: state_nxt_s = DS_ERR2;
            DS_ERR2: state_nxt_s = err_req_s ? DS_ERR1 : DS_OKAY;
            default: state_nxt_s = DS_OKAY;
        endcase
        err_inc_s = (state_nxt_s == DS_ERR1);
    end

    // Data-phase owner and default-slave state; only accepted address phases load the owner.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel_r <= {NUM_SLAVES{1'b0}};
            dp_def_r <= 1'b1;
            state_r  <= DS_OKAY;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                dp_sel_r <= def_hit_s ? {NUM_SLAVES{1'b0}} : HSEL;
                dp_def_r <= def_hit_s;
            end else begin
                dp_sel_r <= dp_sel_r;
                dp_def_r <= dp_def_r;
            end
        end
    end

    // Software-visible error counter and sticky fault flag; clear wins over update.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt_r   <= {CNT_W{1'b0}};
            dec_fault_r <= 1'b0;
        end else if (ERR_CLR) begin
            err_cnt_r   <= {CNT_W{1'b0}};
            dec_fault_r <= 1'b0;
        end else begin
            if (err_inc_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (accept_s && (sel_cnt_s == 2'd2)) begin
                dec_fault_r <= 1'b1;
            end else begin
                dec_fault_r <= dec_fault_r;
            end
        end
    end

    assign HRDATA    = hrdata_s;
    assign HREADY    = hready_s;
    assign HRESP     = hresp_s;
    assign ERR_CNT   = err_cnt_r;
    assign DEC_FAULT = dec_fault_r;

endmodule

// File: tb/tb_ahb_lite_resp_mux.sv
// Directed self-checking bench for ahb_lite_resp_mux; a second instance with CNT_W=2 checks saturation.
module tb_ahb_lite_resp_mux;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  hsel;
    logic [1:0]  htrans;
    logic [63:0] hrdata_s;
    logic [1:0]  hreadyout_s;
    logic [1:0]  hresp_s;
    logic        err_clr;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [7:0]  err_cnt;
    logic        dec_fault;
    logic [31:0] hrdata2;
    logic        hready2;
    logic        hresp2;
    logic [1:0]  err_cnt2;
    logic        dec_fault2;

    int tests;
    int fails;

    ahb_lite_resp_mux #(.DATA_WIDTH(32), .NUM_SLAVES(2), .CNT_W(8)) dut (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HTRANS(htrans),
        .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
        .ERR_CLR(err_clr), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
        .ERR_CNT(err_cnt), .DEC_FAULT(dec_fault)
    );

    ahb_lite_resp_mux #(.DATA_WIDTH(32), .NUM_SLAVES(2), .CNT_W(2)) dut_sat (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HTRANS(htrans),
        .HRDATA_S(hrdata_s), .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s),
        .ERR_CLR(err_clr), .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2),
        .ERR_CNT(err_cnt2), .DEC_FAULT(dec_fault2)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0; hsel = 2'b00; htrans = 2'b00; err_clr = 1'b0;
        hrdata_s = 64'h0; hreadyout_s = 2'b11; hresp_s = 2'b00;
        #12;
        tests++; if (hready !== 1'b1 || hresp !== 1'b0) begin fails++; $display("FAIL reset_ready_resp: got %b/%b want 1/0", hready, hresp); end
        tests++; if (hrdata !== 32'h0) begin fails++; $display("FAIL reset_hrdata: got %h want 00000000", hrdata); end
        tests++; if (err_cnt !== 8'd0 || dec_fault !== 1'b0) begin fails++; $display("FAIL reset_cnt_fault: got %0d/%b want 0/0", err_cnt, dec_fault); end
        tests++; if (hready2 !== 1'b1 || hresp2 !== 1'b0 || hrdata2 !== 32'h0 || err_cnt2 !== 2'd0 || dec_fault2 !== 1'b0) begin
            fails++; $display("FAIL reset_sat_inst: got %b/%b/%h/%0d/%b", hready2, hresp2, hrdata2, err_cnt2, dec_fault2);
        end
        @(negedge hclk);
        hresetn = 1'b1;
        step();
        hsel = 2'b01; htrans = 2'b10; hrdata_s[31:0] = 32'hA5A5_0001;
        step();
        hsel = 2'b00; htrans = 2'b00;
        @(negedge hclk);
        tests++; if (hrdata !== 32'hA5A5_0001 || hready !== 1'b1 || hresp !== 1'b0) begin
            fails++; $display("FAIL first_read: got %h/%b/%b want a5a50001/1/0", hrdata, hready, hresp);
        end
    endtask

    task automatic test_wait_states();
        step();
        hsel = 2'b10; htrans = 2'b10; hrdata_s = {32'h1111_2220, 32'h0000_0BAD}; hreadyout_s = 2'b01;
        step();
        hsel = 2'b01; htrans = 2'b10;
        for (int k = 0; k < 3; k++) begin
            hrdata_s[63:32] = 32'h1111_2220 + 32'(k);
            @(negedge hclk);
            tests++; if (hrdata !== 32'h1111_2220 + 32'(k) || hready !== 1'b0 || hresp !== 1'b0) begin
                fails++; $display("FAIL wait_cycle%0d: got %h/%b/%b want %h/0/0", k, hrdata, hready, hresp, 32'h1111_2220 + 32'(k));
            end
            step();
        end
        hrdata_s[63:32] = 32'h1111_2223; hreadyout_s = 2'b11;
        @(negedge hclk);
        tests++; if (hrdata !== 32'h1111_2223 || hready !== 1'b1 || hresp !== 1'b0) begin
            fails++; $display("FAIL wait_release: got %h/%b/%b want 11112223/1/0", hrdata, hready, hresp);
        end
        step();
        hsel = 2'b00; htrans = 2'b00;
        @(negedge hclk);
        tests++; if (hrdata !== 32'h0000_0BAD || hready !== 1'b1) begin
            fails++; $display("FAIL slave0_after_wait: got %h/%b want 00000bad/1", hrdata, hready);
        end
    endtask

    task automatic test_unmapped();
        hsel = 2'b00; htrans = 2'b10;
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b0 || hresp !== 1'b1 || hrdata !== 32'h0 || err_cnt !== 8'd1) begin
            fails++; $display("FAIL err1_first: got %b/%b/%h/%0d want 0/1/0/1", hready, hresp, hrdata, err_cnt);
        end
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b1 || hresp !== 1'b1 || hrdata !== 32'h0) begin
            fails++; $display("FAIL err2_first: got %b/%b/%h want 1/1/0", hready, hresp, hrdata);
        end
        step();
        htrans = 2'b00;
        @(negedge hclk);
        tests++; if (hready !== 1'b0 || hresp !== 1'b1 || err_cnt !== 8'd2) begin
            fails++; $display("FAIL err1_b2b: got %b/%b/%0d want 0/1/2", hready, hresp, err_cnt);
        end
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b1 || hresp !== 1'b1) begin
            fails++; $display("FAIL err2_b2b: got %b/%b want 1/1", hready, hresp);
        end
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'd2) begin
            fails++; $display("FAIL after_err_okay: got %b/%b/%0d want 1/0/2", hready, hresp, err_cnt);
        end
    endtask

    task automatic test_idle_decode_clr();
        htrans = 2'b01;
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'd2) begin
            fails++; $display("FAIL idle_busy_okay: got %b/%b/%0d want 1/0/2", hready, hresp, err_cnt);
        end
        hsel = 2'b11; htrans = 2'b10;
        step();
        hsel = 2'b00; htrans = 2'b00;
        @(negedge hclk);
        tests++; if (hready !== 1'b0 || hresp !== 1'b1 || dec_fault !== 1'b1 || err_cnt !== 8'd3) begin
            fails++; $display("FAIL multi_sel_err: got %b/%b/%b/%0d want 0/1/1/3", hready, hresp, dec_fault, err_cnt);
        end
        step(); step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge hclk);
        tests++; if (dec_fault !== 1'b0 || err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
            fails++; $display("FAIL err_clr: got %b/%0d/%0d want 0/0/0", dec_fault, err_cnt, err_cnt2);
        end
        hsel = 2'b11; htrans = 2'b10; err_clr = 1'b1;
        step();
        err_clr = 1'b0; hsel = 2'b00; htrans = 2'b00;
        @(negedge hclk);
        tests++; if (dec_fault !== 1'b0 || err_cnt !== 8'd0 || hready !== 1'b0 || hresp !== 1'b1) begin
            fails++; $display("FAIL clr_priority: got %b/%0d/%b/%b want 0/0/0/1", dec_fault, err_cnt, hready, hresp);
        end
        step(); step();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            hsel = 2'b00; htrans = 2'b10;
            step();
            htrans = 2'b00;
            step(); step();
            @(negedge hclk);
            tests++; if (err_cnt2 !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1))) begin
                fails++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, err_cnt2, (k + 1 > 3) ? 3 : k + 1);
            end
        end
        tests++; if (err_cnt !== 8'd5) begin fails++; $display("FAIL wide_cnt: got %0d want 5", err_cnt); end
    endtask

    task automatic test_reset_mid();
        hsel = 2'b00; htrans = 2'b10;
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b0 || hresp !== 1'b1) begin
            fails++; $display("FAIL pre_reset_err1: got %b/%b want 0/1", hready, hresp);
        end
        #2 hresetn = 1'b0;
        #1;
        tests++; if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL async_reset: got %b/%b/%h/%0d want 1/0/0/0", hready, hresp, hrdata, err_cnt);
        end
        #1 hresetn = 1'b1;
        step();
        htrans = 2'b00;
        @(negedge hclk);
        tests++; if (hready !== 1'b0 || hresp !== 1'b1 || err_cnt !== 8'd1) begin
            fails++; $display("FAIL post_reset_err1: got %b/%b/%0d want 0/1/1", hready, hresp, err_cnt);
        end
        step();
        @(negedge hclk);
        tests++; if (hready !== 1'b1 || hresp !== 1'b1) begin
            fails++; $display("FAIL post_reset_err2: got %b/%b want 1/1", hready, hresp);
        end
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_wait_states();
        test_unmapped();
        test_idle_decode_clr();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_lite_resp_mux.md
# ahb_lite_resp_mux

Parametrised AHB-Lite slave-to-master response multiplexor for `NUM_SLAVES` slaves, e.g. the on-chip memory and the AES128 core.
- Registers the one-hot address-phase `HSEL` vector so that `HRDATA`/`HREADY`/`HRESP` follow the slave owning the data phase.
- Embeds a default slave that returns the two-cycle AHB ERROR response for unmapped or multiply-decoded transfers.
- Keeps a saturating error counter and a sticky decode-fault flag for software.

## Interface
- `DATA_WIDTH`, 32, width of read data bus.
- `NUM_SLAVES`, 2, number of slave ports, at least 1.
- `CNT_W`, 8, width of default-slave error counter.

- `HCLK`  in  1  bus clock; everything samples on its rising edge.
- `HRESETn`  in  1  reset, asynchronous assert, active-low.
- `HSEL`  in  NUM_SLAVES  address-phase one-hot select from decoder; bit i = slave i.
- `HTRANS`  in  2  address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `HRDATA_S`  in  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `HREADYOUT_S`  in  NUM_SLAVES  per-slave ready.
- `HRESP_S`  in  NUM_SLAVES  per-slave response (1 = ERROR).
- `ERR_CLR`  in  1  synchronous clear of `ERR_CNT` and `DEC_FAULT`.
- `HRDATA`  out  DATA_WIDTH  muxed read data to master.
- `HREADY`  out  1  muxed ready to master; also fed back to all slaves.
- `HRESP`  out  1  muxed response to master.
- `ERR_CNT`  out  CNT_W  count of default-slave ERROR responses, saturating.
- `DEC_FAULT`  out  1  sticky flag: more than one `HSEL` bit was seen in an accepted address phase.

## Operation
- Address phase is accepted on a rising `HCLK` edge when `HREADY`=1. Only accepted phases update state.
- Data-phase owner register `dp_sel` (NUM_SLAVES bits) and `dp_def` (1 bit), loaded on acceptance:
  - Exactly one `HSEL` bit set: `dp_sel`=`HSEL`, `dp_def`=0. This applies regardless of `HTRANS`; the slave answers IDLE itself.
  - Zero bits, or more than one bit set: `dp_sel`=0, `dp_def`=1.
- Default-slave FSM, states `DS_OKAY`, `DS_ERR1`, `DS_ERR2`:
  - `DS_OKAY`: if an accepted phase has `dp_def` target and `HTRANS` is NONSEQ or SEQ, go to `DS_ERR1`. Otherwise stay.
  - `DS_ERR1`: unconditionally go to `DS_ERR2`.
  - `DS_ERR2`: the phase accepted this cycle (`HREADY`=1) is evaluated exactly as in `DS_OKAY`. The next state is `DS_ERR1` or `DS_OKAY`, so back-to-back errors are supported.
- Output mux, combinational from registers and slave inputs:
  - `dp_def`=0 with `dp_sel` bit i: `HRDATA`=slave i data, `HREADY`=`HREADYOUT_S[i]`, `HRESP`=`HRESP_S[i]`.
  - `dp_def`=1: `HRDATA`=0.
  - `DS_OKAY`: `HREADY`=1, `HRESP`=0.
  - `DS_ERR1`: `HREADY`=0, `HRESP`=1.
  - `DS_ERR2`: `HREADY`=1, `HRESP`=1.
- `ERR_CNT` increments by 1 on each entry to `DS_ERR1` and holds at 2^CNT_W-1.
- `DEC_FAULT` is set on any accepted phase with more than one `HSEL` bit set, independent of `HTRANS`.
- `ERR_CLR` has priority over increment and set in the same cycle.

## Timing
- Reset values:
  - `dp_sel`=0, `dp_def`=1, FSM=`DS_OKAY`.
  - Outputs: `HRDATA`=0, `HREADY`=1, `HRESP`=0, `ERR_CNT`=0, `DEC_FAULT`=0.
- Reset asserted mid-transfer (including `DS_ERR1`) forces these values immediately, without waiting for a clock edge.
- Address phase to owning data phase: 1 cycle. Slave response to master: 0 cycles (combinational).
- While `HREADY`=0, changes on `HSEL`/`HTRANS` have no effect. `dp_sel` holds until the slave raises `HREADYOUT`.
- Default-slave ERROR response is exactly 2 cycles: the `DS_ERR1` cycle, then the `DS_ERR2` cycle.
- IDLE or BUSY to an unmapped address gives a zero-wait OKAY. `ERR_CNT` does not change.

## Test plan
- Reset check: assert `HRESETn`=0 → `HREADY`=1, `HRESP`=0, `HRDATA`=0, `ERR_CNT`=0.
  - Then NONSEQ with `HSEL`=01, slave 0 data 0xA5A5_0001, ready=1 → next cycle `HRDATA`=0xA5A5_0001, `HREADY`=1, `HRESP`=0.
- Wait states: slave 1 selected with `HREADYOUT_S[1]` low for 3 cycles, `HSEL` switched to 01 meanwhile → output tracks slave 1 for all 4 cycles.
  - Slave 0 owns the data phase only after `HREADY`=1.
- Unmapped NONSEQ (`HSEL`=00) → one cycle `HREADY`=0/`HRESP`=1, then `HREADY`=1/`HRESP`=1, `HRDATA`=0.
  - `ERR_CNT`=1. A back-to-back second unmapped NONSEQ accepted in `DS_ERR2` → a second 2-cycle error, `ERR_CNT`=2.
- Unmapped IDLE → `HREADY`=1, `HRESP`=0, `ERR_CNT` unchanged.
  - `HSEL`=11 with NONSEQ → ERROR response and `DEC_FAULT`=1.
  - `ERR_CLR`=1 → `DEC_FAULT`=0, `ERR_CNT`=0.
- `CNT_W`=2: 5 unmapped NONSEQ transfers → `ERR_CNT` saturates at 3.
- `HRESETn` pulsed low during `DS_ERR1` → `HREADY`=1 and `HRESP`=0 immediately. The next unmapped NONSEQ behaves normally.
